store_coalescer: RTL

Parametrised store-gathering unit for the multicore memory path. Each core writes DATA_W-bit values into its own lane of a shared row-staging register file. Cores then issue store requests against a row. The block gathers requests from all active cores for that row and issues one wide, lane-masked memory write. A timeout mode (new in this generation) flushes a partial row when a core fails to request in time.

---
 rtl/store_coalescer_pkg.sv | 20 ++
 rtl/store_row_regfile.sv | 42 ++++
 rtl/store_coalescer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/store_coalescer_pkg.sv
// Shared state type and bus-slicing helpers for the store coalescer.
package store_coalescer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        ACK     = 2'd3
    } state_t;

    // Offset of element idx inside a flat LSB-first bus of width-bit elements.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/store_row_regfile.sv
// Row staging register file: one write port per lane, one row read port with write-through bypass.
module store_row_regfile
    import store_coalescer_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DATA_W     = 16,
    parameter int ROW_ADDR_W = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CORES-1:0]            wr_en,
    input  logic [NUM_CORES*ROW_ADDR_W-1:0] wr_addr,
    input  logic [NUM_CORES*DATA_W-1:0]     wr_data,
    input  logic [ROW_ADDR_W-1:0]           rd_addr,
    output logic [NUM_CORES*DATA_W-1:0]     rd_data
);
    localparam int NUM_ROWS = 2 ** ROW_ADDR_W;

    logic [NUM_CORES*DATA_W-1:0] rows [NUM_ROWS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ROWS; r++) rows[r] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (wr_en[i])
                    rows[wr_addr[slice_lsb(i, ROW_ADDR_W) +: ROW_ADDR_W]][slice_lsb(i, DATA_W) +: DATA_W]
                        <= wr_data[slice_lsb(i, DATA_W) +: DATA_W];
            end
        end
    end

    // Same-cycle writes to the row being read win, so a snapshot taken now sees them.
    always_comb begin
        rd_data = rows[rd_addr];
        for (int i = 0; i < NUM_CORES; i++) begin
            if (wr_en[i] && (wr_addr[slice_lsb(i, ROW_ADDR_W) +: ROW_ADDR_W] == rd_addr))
                rd_data[slice_lsb(i, DATA_W) +: DATA_W] = wr_data[slice_lsb(i, DATA_W) +: DATA_W];
        end
    end

endmodule

// File: rtl/store_coalescer.sv
// Gathers per-core store requests for one row into a single lane-masked memory write.
module store_coalescer
    import store_coalescer_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DATA_W     = 16,
    parameter int ROW_ADDR_W = 4,
    parameter int MEM_ADDR_W = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CORES-1:0]            active_mask,
    input  logic [NUM_CORES-1:0]            wr_en,
    input  logic [NUM_CORES*ROW_ADDR_W-1:0] wr_addr,
    input  logic [NUM_CORES*DATA_W-1:0]     wr_data,
    input  logic [NUM_CORES-1:0]            st_req,
    input  logic [NUM_CORES*ROW_ADDR_W-1:0] st_row,
    input  logic [MEM_ADDR_W-1:0]           base_addr,
    output logic [NUM_CORES-1:0]            st_ack,
    output logic                            busy,
    output logic                            mem_valid,
    input  logic                            mem_ready,
    output logic [MEM_ADDR_W-1:0]           mem_addr,
    output logic [NUM_CORES*DATA_W-1:0]     mem_data,
    output logic [NUM_CORES-1:0]            mem_lane_en
);
    localparam int TIMER_W = timer_width(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                      state;
    logic [ROW_ADDR_W-1:0]       cur_row;
    logic [ROW_ADDR_W-1:0]       first_row;
    logic [ROW_ADDR_W-1:0]       match_row;
    logic [NUM_CORES-1:0]        pend;
    logic [NUM_CORES-1:0]        req_q;
    logic [NUM_CORES-1:0]        hits;
    logic [NUM_CORES-1:0]        gathered;
    logic [TIMER_W-1:0]          timer;
    logic [NUM_CORES*DATA_W-1:0] rd_data;
    logic [NUM_CORES*DATA_W-1:0] snapshot;
    logic [MEM_ADDR_W-1:0]       issue_addr;
    logic                        covered;
    logic                        timed_out;

    store_row_regfile #(
        .NUM_CORES  (NUM_CORES),
        .DATA_W     (DATA_W),
        .ROW_ADDR_W (ROW_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (cur_row),
        .rd_data (rd_data)
    );

    assign req_q = st_req & active_mask;

    // Lowest-index requester picks the row for a new round.
    always_comb begin
        first_row = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req_q[i]) first_row = st_row[slice_lsb(i, ROW_ADDR_W) +: ROW_ADDR_W];
        end
    end

    assign match_row = (state == IDLE) ? first_row : cur_row;

    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_CORES; i++)
            hits[i] = req_q[i] && (st_row[slice_lsb(i, ROW_ADDR_W) +: ROW_ADDR_W] == match_row);
    end

    assign gathered  = pend | hits;
    assign covered   = (active_mask & ~gathered) == '0;
    assign timed_out = (TIMEOUT != 0) && (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_row <= '0;
            pend    <= '0;
            timer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_q) begin
                        cur_row <= first_row;
                        pend    <= hits;
                        timer   <= '0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    pend <= gathered;
                    if (covered || timed_out) begin
                        snapshot   <= rd_data;
                        issue_addr <= base_addr + MEM_ADDR_W'(cur_row);
                        state      <= ISSUE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ISSUE: begin
                    if (mem_ready) state <= ACK;
                end
                ACK: begin
                    pend  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side outputs are held at zero outside ISSUE.
    assign busy        = (state != IDLE);
    assign mem_valid   = (state == ISSUE);
    assign mem_addr    = mem_valid ? issue_addr : '0;
    assign mem_data    = mem_valid ? snapshot : '0;
    assign mem_lane_en = mem_valid ? pend : '0;
    assign st_ack      = (state == ACK) ? pend : '0;

endmodule
